// File: rtl/arbitro_somatorio_pkg.sv
// Shared definitions for the round-robin summation scheduler.
//   estado_t   : FSM state encoding (IDLE, ADD, DONE)
//   *_DEF      : default parameter values for N_REQ, W, CW
//   ID_W       : requester-id width for the default N_REQ
package somatorio_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 6;
  localparam int CW_DEF    = 6;
  localparam int ID_W      = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/arbitro_somatorio_nucleo.sv
// nucleo_soma: iterative summation core (one add per clock).
//   clk, reset : clock, async active-high reset
//   load       : latch operand/count, clear accumulator and overflow
//   step       : perform one addition if the count is not yet exhausted
//   operand    : signed addend (W bits)
//   count      : number of additions (CW bits, unsigned)
//   acc        : running sum, modulo 2^W
//   zero       : remaining count is zero
//   ovf        : sticky signed overflow since the last load
module nucleo_soma
  import somatorio_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  operand,
  input  logic [CW-1:0] count,
  output logic [W-1:0]  acc,
  output logic          zero,
  output logic          ovf
);

  logic [W-1:0]  op;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sum;
  logic          ovf_step;

  assign sum  = acc + op;
  assign zero = (cnt == '0);
  // Overflow only when both addends share a sign and the sum flips it.
  assign ovf_step = (acc[W-1] == op[W-1]) && (sum[W-1] != op[W-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op  <= '0;
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      op  <= operand;
      cnt <= count;
      acc <= '0;
      ovf <= 1'b0;
    end else if (step && !zero) begin
      acc <= sum;
      cnt <= cnt - 1'b1;
      ovf <= ovf | ovf_step;
    end
  end

endmodule

// File: rtl/arbitro_somatorio.sv
// arbitro_somatorio: round-robin scheduler sharing one iterative summation
// core among N_REQ requesters. Computes valor*contagem as repeated addition.
//   clk, reset : clock, async active-high reset
//   req        : per-requester request level (sampled only in IDLE)
//   valor      : flat signed operands, requester i at [i*W +: W]
//   contagem   : flat unsigned counts, requester i at [i*CW +: CW]
//   gnt        : one-hot grant, high for the first ADD cycle
//   busy       : state != IDLE
//   done       : one-cycle result-valid pulse
//   done_id    : requester id of the result (held)
//   resultado  : final sum modulo 2^W (held)
//   overflow   : sticky signed overflow of the job (held)
module arbitro_somatorio
  import somatorio_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         valor,
  input  logic [N_REQ*CW-1:0]        contagem,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [W-1:0]               resultado,
  output logic                       overflow
);

  localparam int IDB = $clog2(N_REQ);

  estado_t        state, state_nxt;
  logic [IDB-1:0] ptr, id, win;
  logic           found;
  int             cand;
  logic [W-1:0]   op_sel;
  logic [CW-1:0]  cnt_sel;
  logic           load, step, zero, ovf;
  logic [W-1:0]   acc;

  // Rotating priority: first set req bit starting at ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IDB'(cand);
      end
    end
  end

  assign op_sel  = valor[int'(win)*W +: W];
  assign cnt_sel = contagem[int'(win)*CW +: CW];
  assign load    = (state == IDLE) && found;
  assign step    = (state == ADD);

  nucleo_soma #(.W(W), .CW(CW)) u_nucleo (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .operand (op_sel),
    .count   (cnt_sel),
    .acc     (acc),
    .zero    (zero),
    .ovf     (ovf)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: the zero test comes first, so count k takes k+1 ADD cycles.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = ADD;
      ADD:     if (zero)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
  end

  // Registered outputs, grant bookkeeping and round-robin pointer.
  // done is registered from the DONE state, so it shows one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      id        <= '0;
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      resultado <= '0;
      overflow  <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      if (load) begin
        id  <= win;
        ptr <= (int'(win) == N_REQ - 1) ? '0 : win + IDB'(1);
        gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
      end
      if (state == DONE) begin
        done      <= 1'b1;
        done_id   <= id;
        resultado <= acc;
        overflow  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_somatorio.sv
module tb_arbitro_somatorio;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] valor;
  logic [23:0] contagem;
  logic [3:0]  gnt;
  logic        busy, done, overflow;
  logic [1:0]  done_id;
  logic [5:0]  resultado;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arbitro_somatorio dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .valor     (valor),
    .contagem  (contagem),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .resultado (resultado),
    .overflow  (overflow)
  );

  typedef struct {
    int         id;
    logic [5:0] v;
    int         k;
    logic [5:0] res;
    logic       ovf;
    bit         disturb;
  } vec_t;

  vec_t tbl[9];
  int   got_ids[5];
  int   n_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input vec_t t);
    int   cyc;
    bit   got;
    bit   stray_gnt;
    logic [5:0] held;
    valor    = {4{6'b010101}};
    contagem = {4{6'd9}};
    req      = '0;
    req[t.id] = 1'b1;
    valor[t.id*6 +: 6]    = t.v;
    contagem[t.id*6 +: 6] = 6'(t.k);
    tick();                                   // sampling edge
    chk($sformatf("gnt_id%0d", t.id), 32'(gnt), 32'(4'b1 << t.id));
    chk("busy_after_grant", 32'(busy), 32'd1);
    req = '0;
    cyc = 0; got = 0; stray_gnt = 0;
    while (cyc < 300 && !got) begin
      tick();
      cyc++;
      if (gnt != 0) stray_gnt = 1;
      if (t.disturb) begin
        if (cyc < t.k) begin
          req      = 4'($urandom) | 4'b1011;
          valor    = 24'($urandom);
          contagem = 24'($urandom);
        end else begin
          req = '0;
        end
      end
      got = done;
    end
    chk("gnt_single_pulse", 32'(stray_gnt), 32'd0);
    chk("done_seen", 32'(got), 32'd1);
    chk($sformatf("latency_k%0d", t.k), 32'(cyc), 32'(t.k + 2));
    chk($sformatf("resultado_v%0h_k%0d", t.v, t.k), 32'(resultado), 32'(t.res));
    chk("done_id", 32'(done_id), 32'(t.id));
    chk($sformatf("overflow_v%0h_k%0d", t.v, t.k), 32'(overflow), 32'(t.ovf));
    held = resultado;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("resultado_held", 32'(resultado), 32'(held));
  endtask

  // Record the first n grants seen; optionally drop each granted req.
  task automatic collect(input int n, input bit hold);
    int id;
    n_got = 0;
    for (int i = 0; i < 5; i++) got_ids[i] = -1;
    for (int c = 0; c < 200 && n_got < n; c++) begin
      tick();
      if (gnt != 0) begin
        id = 0;
        for (int j = 0; j < 4; j++) if (gnt[j]) id = j;
        got_ids[n_got] = id;
        n_got++;
        if (!hold) req[id] = 1'b0;
      end
    end
    chk("grants_collected", 32'(n_got), 32'(n));
  endtask

  task automatic wait_idle;
    int c;
    c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    tick();
    tick();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int  rr_exp[5];
    bit  spurious;
    tbl[0] = '{1, 6'd5,       3,  6'd15,      1'b0, 1'b0};
    tbl[1] = '{0, 6'd7,       0,  6'd0,       1'b0, 1'b0};
    tbl[2] = '{2, 6'd20,      2,  6'b101000,  1'b1, 1'b0};
    tbl[3] = '{3, 6'b111101,  4,  6'b110100,  1'b0, 1'b0};
    tbl[4] = '{1, 6'd31,      1,  6'd31,      1'b0, 1'b0};
    tbl[5] = '{0, 6'b100000,  2,  6'd0,       1'b1, 1'b0};
    tbl[6] = '{3, 6'd1,       63, 6'b111111,  1'b1, 1'b0};
    tbl[7] = '{1, 6'd16,      4,  6'd0,       1'b1, 1'b0};
    tbl[8] = '{2, 6'd4,       3,  6'd12,      1'b0, 1'b1};

    reset = 1'b1; req = '0; valor = '0; contagem = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_resultado", 32'(resultado), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i]);
      tick();
    end

    // Round robin with all requests held: 0,1,2,3,0 from ptr=0.
    do_reset();
    for (int i = 0; i < 4; i++) valor[i*6 +: 6] = 6'd5;
    contagem = '0;
    req = 4'b1111;
    rr_exp = '{0, 1, 2, 3, 0};
    collect(5, 1'b1);
    req = '0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order%0d", i), 32'(got_ids[i]), 32'(rr_exp[i]));
    wait_idle();

    // ptr=1 now: with 0 and 2 pending, 2 wins first.
    req = 4'b0101;
    collect(2, 1'b0);
    req = '0;
    chk("rr_ptr1_first", 32'(got_ids[0]), 32'd2);
    chk("rr_ptr1_second", 32'(got_ids[1]), 32'd0);
    wait_idle();

    // Reset mid-job: leaves a nonzero result in place first (ptr ends at 2).
    run_job(tbl[0]);
    tick();
    req = 4'b0010;
    valor[6 +: 6] = 6'd1;
    contagem[6 +: 6] = 6'd10;
    tick();                                   // sampling edge, ADD cycle 1
    req = '0;
    tick();
    tick();
    tick();                                   // ADD cycle 4
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resultado", 32'(resultado), 32'd0);
    chk("midrst_done_id", 32'(done_id), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    tick();
    reset = 1'b0;
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) spurious = 1;
    end
    chk("midrst_no_done", 32'(spurious), 32'd0);
    req = 4'b1001;
    collect(1, 1'b0);
    req = '0;
    chk("midrst_ptr_reset", 32'(got_ids[0]), 32'd0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
